// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding
// and the operand magnitude helper.
package mult_pkg;

    // Widest operand the design supports; the magnitude helper works at this width.
    localparam int MAX_W = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_FIX  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Magnitude of a value already sign- or zero-extended to MAX_W bits.
    // The most negative operand maps to 2^(W-1) exactly once the caller
    // truncates the result back to its own operand width.
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] value,
                                               input logic             sign_en);
        abs_w = (sign_en && value[MAX_W-1]) ? (~value + 1'b1) : value;
    endfunction

endpackage

// File: rtl/mult_addshift_step.sv
// One add-shift iteration of the multiplier, plus the full-adder cell it is
// built from. Purely combinational.

module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module mult_addshift_step #(
    parameter int WIDTH = 4
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mplier,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0]   mplier_next
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    // Multiplicand is added only when the current multiplier bit is set.
    assign addend   = mplier[0] ? mcand : '0;
    assign carry[0] = 1'b0;

    // Ripple adder over the upper half of the accumulator; its carry-out
    // becomes the new accumulator MSB after the shift.
    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        fa u_fa (
            .a    (acc[WIDTH+i]),
            .b    (addend[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    // {carry, acc, mplier} shifted right by one: the accumulator's LSB
    // falls into the multiplier register, whose LSB is consumed.
    assign acc_next    = {carry[WIDTH], sum, acc[WIDTH-1:1]};
    assign mplier_next = {acc[0], mplier[WIDTH-1:1]};

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential WIDTH x WIDTH shift-add multiplier, unsigned or two's-complement.
// Magnitudes are multiplied over WIDTH iterations; the sign is applied in a
// final FIX cycle. start/busy/done handshake, ena freezes all state.
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mcand;
    logic               neg;

    logic [MAX_W-1:0]   a_ext;
    logic [MAX_W-1:0]   b_ext;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier_next;
    logic               accept;

    // Extend operands to the helper width, sign-extending only in signed mode.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        a_ext = MAX_W'(a);
        b_ext = MAX_W'(b);
        if (signed_mode) begin
            a_ext = MAX_W'($signed(a));
            b_ext = MAX_W'($signed(b));
        end
    end

    assign mag_a  = WIDTH'(abs_w(a_ext, signed_mode));
    assign mag_b  = WIDTH'(abs_w(b_ext, signed_mode));
    assign accept = start && (state == ST_IDLE || state == ST_DONE);

    mult_addshift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc         (acc),
        .mplier      (mplier),
        .mcand       (mcand),
        .acc_next    (acc_next),
        .mplier_next (mplier_next)
    );

    // FSM, iteration counter, operand registers and result register; all
    // state advances only on enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            acc     <= '0;
            mplier  <= '0;
            mcand   <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else if (ena) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= CNT_W'(WIDTH);
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier_next;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    product <= neg ? -acc : acc;
                    state   <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode the registered state, so they freeze with ena.
    assign busy = (state == ST_RUN) || (state == ST_FIX);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed self-checking bench for seq_shift_add_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_shift_add_multiplier;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;

    logic       start4, sm4, busy4, done4;
    logic [3:0] a4, b4;
    logic [7:0] prod4;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        s;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec8_t;

    always #5 clk = ~clk;

    seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .start       (start4),
        .signed_mode (sm4),
        .a           (a4),
        .b           (b4),
        .busy        (busy4),
        .done        (done4),
        .product     (prod4)
    );

    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .start       (start8),
        .signed_mode (sm8),
        .a           (a8),
        .b           (b8),
        .busy        (busy8),
        .done        (done8),
        .product     (prod8)
    );

    // Launch one WIDTH=4 operation from a negedge and wait (bounded) for done.
    task automatic run_op4(input logic s, input logic [3:0] aa, input logic [3:0] bb,
                           output logic [7:0] p, output int lat, output int nbusy);
        sm4 = s; a4 = aa; b4 = bb; start4 = 1'b1;
        lat = 0; nbusy = 0; p = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (busy4) nbusy++;
            if (done4) begin
                lat = i;
                p   = prod4;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1;
        start4 = 0; sm4 = 0; a4 = 0; b4 = 0;
        start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
        #12;
        checks++;
        if ({busy4, done4, prod4} !== 10'd0) begin
            errors++; $display("FAIL reset_w4: got busy=%b done=%b product=%h expected 0 0 00", busy4, done4, prod4);
        end
        checks++;
        if ({busy8, done8, prod8} !== 18'd0) begin
            errors++; $display("FAIL reset_w8: got busy=%b done=%b product=%h expected 0 0 0000", busy8, done8, prod8);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [7:0] p;
        int lat, nb;
        run_op4(1'b0, 4'd15, 4'd15, p, lat, nb);
        checks++;
        if (p !== 8'hE1) begin errors++; $display("FAIL u_15x15: got %h expected e1", p); end
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL u_latency: got %0d expected 6", lat); end
        checks++;
        if (nb !== 5) begin errors++; $display("FAIL u_busy_cycles: got %0d expected 5", nb); end
        @(negedge clk);
        checks++;
        if (done4 !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b expected 0", done4); end
        checks++;
        if (prod4 !== 8'hE1) begin errors++; $display("FAIL product_hold: got %h expected e1", prod4); end
        run_op4(1'b0, 4'd9, 4'd11, p, lat, nb);
        checks++;
        if (p !== 8'h63) begin errors++; $display("FAIL u_9x11: got %h expected 63", p); end
    endtask

    task automatic test_signed();
        logic [3:0] av [4] = '{4'h8, 4'h7, 4'h8, 4'h0};
        logic [3:0] bv [4] = '{4'h8, 4'hD, 4'h7, 4'hB};
        logic [7:0] ev [4] = '{8'h40, 8'hEB, 8'hC8, 8'h00};
        logic [7:0] p;
        int lat, nb;
        // Called back to back: each new start lands in the DONE cycle.
        for (int k = 0; k < 4; k++) begin
            run_op4(1'b1, av[k], bv[k], p, lat, nb);
            checks++;
            if (p !== ev[k]) begin
                errors++; $display("FAIL signed_%0d: got %h expected %h", k, p, ev[k]);
            end
            checks++;
            if (lat !== 6) begin
                errors++; $display("FAIL signed_lat_%0d: got %0d expected 6", k, lat);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_start_busy();
        int ndone = 0, first = 0;
        logic [7:0] pv = '0;
        sm4 = 0; a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done4) begin
                ndone++;
                if (first == 0) first = i;
                pv = prod4;
            end
            case (i)
                1: start4 = 1'b0;
                2: begin start4 = 1'b1; a4 = 4'd15; b4 = 4'd15; sm4 = 1'b1; end
                3: start4 = 1'b0;
                default: ;
            endcase
        end
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL busy_start_done_count: got %0d expected 1", ndone); end
        checks++;
        if (first !== 6) begin errors++; $display("FAIL busy_start_latency: got %0d expected 6", first); end
        checks++;
        if (pv !== 8'h0F) begin errors++; $display("FAIL busy_start_result: got %h expected 0f", pv); end
    endtask

    task automatic test_ena_stall();
        int ndone = 0, first = 0;
        logic [7:0] pv = '0;
        sm4 = 0; a4 = 4'd5; b4 = 4'd6; start4 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done4) begin
                ndone++;
                if (first == 0) first = i;
                pv = prod4;
            end
            if (i == 5) begin
                checks++;
                if ({busy4, prod4} !== {1'b1, 8'h0F}) begin
                    errors++; $display("FAIL stall_hold: got busy=%b product=%h expected 1 0f", busy4, prod4);
                end
            end
            case (i)
                1:  start4 = 1'b0;
                3:  ena = 1'b0;
                6:  ena = 1'b1;
                9:  ena = 1'b0;
                11: ena = 1'b1;
                default: ;
            endcase
        end
        checks++;
        if (first !== 9) begin errors++; $display("FAIL stall_latency: got %0d expected 9", first); end
        checks++;
        if (pv !== 8'h1E) begin errors++; $display("FAIL stall_result: got %h expected 1e", pv); end
        checks++;
        if (ndone !== 3) begin errors++; $display("FAIL stall_done_span: got %0d expected 3", ndone); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] p;
        int lat, nb;
        sm4 = 0; a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy4 !== 1'b1) begin errors++; $display("FAIL pre_abort_busy: got %b expected 1", busy4); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy4, done4, prod4} !== 10'd0) begin
            errors++; $display("FAIL async_abort: got busy=%b done=%b product=%h expected 0 0 00", busy4, done4, prod4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op4(1'b1, 4'h9, 4'h9, p, lat, nb);
        checks++;
        if (p !== 8'h31) begin errors++; $display("FAIL post_reset_result: got %h expected 31", p); end
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL post_reset_latency: got %0d expected 6", lat); end
    endtask

    task automatic test_exhaustive4();
        logic [7:0] p, e;
        int lat, nb, ai, bi;
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run_op4(s[0], x[3:0], y[3:0], p, lat, nb);
                    ai = (s == 1 && x >= 8) ? x - 16 : x;
                    bi = (s == 1 && y >= 8) ? y - 16 : y;
                    e  = 8'(ai * bi);
                    checks++;
                    if (p !== e) begin
                        errors++; $display("FAIL w4_s%0d_%0dx%0d: got %h expected %h", s, x, y, p, e);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        vec8_t v8 [9];
        int k = 0, last = 0;
        v8[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        v8[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        v8[2] = '{1'b1, 8'h7F, 8'h80, 16'hC080};
        v8[3] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        v8[4] = '{1'b0, 8'h00, 8'hC8, 16'h0000};
        v8[5] = '{1'b0, 8'h10, 8'h10, 16'h0100};
        v8[6] = '{1'b1, 8'hFE, 8'h03, 16'hFFFA};
        v8[7] = '{1'b0, 8'hC8, 8'h03, 16'h0258};
        v8[8] = '{1'b1, 8'h64, 8'h9C, 16'hD8F0};
        sm8 = v8[0].s; a8 = v8[0].a; b8 = v8[0].b; start8 = 1'b1;
        for (int i = 1; i <= 200 && k < 9; i++) begin
            @(negedge clk);
            if (done8) begin
                checks++;
                if (prod8 !== v8[k].p) begin
                    errors++; $display("FAIL w8_vec_%0d: got %h expected %h", k, prod8, v8[k].p);
                end
                checks++;
                if (i - last !== 10) begin
                    errors++; $display("FAIL w8_spacing_%0d: got %0d expected 10", k, i - last);
                end
                last = i;
                k++;
                if (k < 9) begin
                    sm8 = v8[k].s; a8 = v8[k].a; b8 = v8[k].b;
                end else begin
                    start8 = 1'b0;
                end
            end
        end
        checks++;
        if (k !== 9) begin errors++; $display("FAIL w8_timeout: got %0d results expected 9", k); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_start_busy();
        test_ena_stall();
        test_reset_mid();
        test_exhaustive4();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
